// File: rtl/sound_pkg.sv
// ----------------------------------------------------------------------------
// sound_pkg
// Shared definitions for the sound-effect scheduler:
//   - sound code constants (0 = no sound, 1..7 = effects)
//   - fixed issue priority table, index 0 = highest priority
//   - scheduler FSM state encoding
//   - small helper to count set bits in a request mask
// ----------------------------------------------------------------------------
package sound_pkg;

    localparam int NUM_SND = 7;

    localparam logic [2:0] SND_NONE      = 3'd0;
    localparam logic [2:0] SND_SELECT    = 3'd1;
    localparam logic [2:0] SND_CANCEL    = 3'd2;
    localparam logic [2:0] SND_MOVE      = 3'd3;
    localparam logic [2:0] SND_CAPTURE   = 3'd4;
    localparam logic [2:0] SND_ILLEGAL   = 3'd5;
    localparam logic [2:0] SND_PROMOTION = 3'd6;
    localparam logic [2:0] SND_GAMEOVER  = 3'd7;

    // Packed concatenation puts the last element at index 0, so index 0
    // (game over) is the most urgent and index 6 (select) the least.
    localparam logic [NUM_SND-1:0][2:0] PRIO_ORDER = {
        SND_SELECT, SND_CANCEL, SND_MOVE, SND_CAPTURE,
        SND_PROMOTION, SND_ILLEGAL, SND_GAMEOVER
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE,
        ST_GAP
    } state_t;

    function automatic logic [3:0] popcnt7(input logic [NUM_SND-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_SND; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sound_prio_pick.sv
// ----------------------------------------------------------------------------
// sound_prio_pick
// Combinational fixed-priority pick over the pending request mask.
// Ports:
//   i_mask  [6:0]  pending mask, bit i-1 = sound code i
//   o_code  [2:0]  highest-priority pending code (0 when mask is empty)
//   o_clr   [6:0]  one-hot mask of the picked bit (0 when mask is empty)
// ----------------------------------------------------------------------------
module sound_prio_pick
    import sound_pkg::*;
(
    input  logic [NUM_SND-1:0] i_mask,
    output logic [2:0]         o_code,
    output logic [NUM_SND-1:0] o_clr
);

    // Walk from lowest to highest priority so the last hit wins.
    always_comb begin
        o_code = SND_NONE;
        o_clr  = '0;
        for (int i = NUM_SND - 1; i >= 0; i--) begin
            if (i_mask[PRIO_ORDER[3'(i)] - 3'd1]) begin
                o_code = PRIO_ORDER[3'(i)];
                o_clr  = '0;
                o_clr[PRIO_ORDER[3'(i)] - 3'd1] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sound_scheduler.sv
// ----------------------------------------------------------------------------
// sound_scheduler
// Coalesces sound-effect requests into a pending mask and issues them one at
// a time, highest priority first, to a single sound player.
// Ports:
//   clk           system clock
//   rstn          asynchronous active-low reset
//   req   [6:0]   request pulses, bit i-1 requests code i
//   mute          discards pending requests and blocks new issues
//   player_busy   player start/busy feedback
//   sound_code    code presented to the player, changes only on issue
//   play_sound    one-cycle issue pulse
//   pending [6:0] current pending mask
//   active        high from issue until the post-play gap has elapsed
//   timeout_err   one-cycle pulse when the player fails to start
//   coalesce_cnt  saturating count of requests merged into a pending bit
//   timeout_cnt   saturating count of start timeouts
// ----------------------------------------------------------------------------
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int START_TIMEOUT = 16,
    parameter int GAP_CYCLES    = 1000000,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [6:0]         req,
    input  logic               mute,
    input  logic               player_busy,
    output logic [2:0]         sound_code,
    output logic               play_sound,
    output logic [6:0]         pending,
    output logic               active,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   coalesce_cnt,
    output logic [CNT_W-1:0]   timeout_cnt
);

    // One timer serves both the start timeout and the gap; size it for the
    // larger of the two.
    localparam int TMR_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] START_LAST = TMR_W'((START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0);
    // GAP_CYCLES=0 still spends one cycle in GAP, so its last count is 0.
    localparam logic [TMR_W-1:0] GAP_LAST   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [3:0]       b);
        logic [CNT_W+3:0] s;
        s = {4'b0000, a} + {{CNT_W{1'b0}}, b};
        return (|s[CNT_W+3:CNT_W]) ? '1 : s[CNT_W-1:0];
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TMR_W-1:0]    r_timer;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic [NUM_SND-1:0]  r_pending;
    logic [NUM_SND-1:0]  r_clr;
    logic [2:0]          r_code;
    logic                r_play;
    logic                r_terr;
    logic                r_active;
    logic [CNT_W-1:0]    r_coal_cnt;
    logic [CNT_W-1:0]    r_tout_cnt;

    logic [2:0]          w_pick_code;
    logic [NUM_SND-1:0]  w_pick_clr;
    logic [NUM_SND-1:0]  w_clear;
    logic [NUM_SND-1:0]  w_pend_nxt;
    logic [NUM_SND-1:0]  w_coal_bits;
    logic                w_issue;
    logic                w_timeout;

    sound_prio_pick u_pick (
        .i_mask (r_pending),
        .o_code (w_pick_code),
        .o_clr  (w_pick_clr)
    );

    // The issued bit is cleared at the end of the ISSUE cycle using the mask
    // captured with the code, so a request arriving in between cannot change
    // which bit gets cleared. A req on that same bit re-sets it.
    assign w_clear     = (r_state == ST_ISSUE) ? r_clr : '0;
    assign w_pend_nxt  = mute ? '0 : ((r_pending & ~w_clear) | req);
    assign w_coal_bits = mute ? '0 : (req & r_pending & ~w_clear);

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_issue     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|r_pending) && !mute && !player_busy) begin
                    w_state_nxt = ST_ISSUE;
                    w_issue     = 1'b1;
                    w_timer_nxt = '0;
                end
            end
            ST_ISSUE: begin
                // Timer counts cycles since the play pulse, so the ISSUE
                // cycle itself is count 0.
                w_state_nxt = ST_WAIT_START;
                w_timer_nxt = r_timer + 1'b1;
            end
            ST_WAIT_START: begin
                if (player_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_timer == START_LAST) begin
                    w_state_nxt = ST_GAP;
                    w_timeout   = 1'b1;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!player_busy) begin
                    w_state_nxt = ST_GAP;
                    w_timer_nxt = '0;
                end
            end
            ST_GAP: begin
                if (r_timer == GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_pending  <= '0;
            r_clr      <= '0;
            r_code     <= SND_NONE;
            r_play     <= 1'b0;
            r_terr     <= 1'b0;
            r_active   <= 1'b0;
            r_coal_cnt <= '0;
            r_tout_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_pending  <= w_pend_nxt;
            r_play     <= w_issue;
            r_terr     <= w_timeout;
            r_active   <= (w_state_nxt != ST_IDLE);
            r_coal_cnt <= sat_add(r_coal_cnt, popcnt7(w_coal_bits));
            if (w_issue) begin
                r_code <= w_pick_code;
                r_clr  <= w_pick_clr;
            end
            if (w_timeout) begin
                r_tout_cnt <= sat_add(r_tout_cnt, 4'd1);
            end
        end
    end

    assign sound_code   = r_code;
    assign play_sound   = r_play;
    assign pending      = r_pending;
    assign active       = r_active;
    assign timeout_err  = r_terr;
    assign coalesce_cnt = r_coal_cnt;
    assign timeout_cnt  = r_tout_cnt;

endmodule

// File: doc/sound_scheduler.md
Name: sound_scheduler

Overview:
- Collects sound-effect requests from the game logic and issues them to the single Sound player, one at a time.
- Request sources: select, cancel, move, capture, illegal, promotion, game over.
- Requests are coalesced into a pending mask. When the player is idle, the highest-priority pending code is picked, and one play_sound pulse is driven with a stable sound_code.
- Sits between the chess game FSM and Sound; the player's start output is fed back as player_busy.

Parameters:
- START_TIMEOUT, 16, clk cycles to wait for player_busy to rise after a play_sound pulse.
- GAP_CYCLES, 1000000, idle clk cycles after player_busy falls before the next issue (10 ms at 100 MHz).
- CNT_W, 8, width of the saturating diagnostic counters.

Ports:
- clk  in  1  system clock (100 MHz)
- rstn  in  1  asynchronous active-low reset
- req  in  7  request pulses; bit i-1 requests code i (1=select, 2=cancel, 3=move, 4=capture, 5=illegal, 6=promotion, 7=game over)
- mute  in  1  level; discards pending requests and blocks new issues
- player_busy  in  1  Sound.start; high while a sound plays
- sound_code  out  3  code presented to Sound; held stable from issue until the next issue
- play_sound  out  1  one-cycle issue pulse to Sound
- pending  out  7  current pending mask
- active  out  1  high from issue until the player finishes and the gap elapses
- timeout_err  out  1  one-cycle pulse when the player fails to start
- coalesce_cnt  out  CNT_W  saturating count of requests merged into an already-pending bit
- timeout_cnt  out  CNT_W  saturating count of timeouts

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, pending=0, sound_code=0, play_sound=0, active=0, timeout_err=0, both counters=0, internal timers=0.
- Request capture, every cycle:
  - pending_next = (pending & ~clear_mask) | req.
  - A req bit set in the same cycle its bit is cleared by an issue wins: the bit stays pending.
  - Each req bit that is already pending and not being cleared adds 1 to coalesce_cnt. Several bits in one cycle add their sum; the counter saturates at all-ones.
- Mute: while mute=1, pending is forced to 0 (req ignored) and no issue occurs. A sound already playing is not aborted.
- Priority, highest first: 7, 5, 6, 4, 3, 2, 1. Fixed, combinational pick over pending.
- FSM:
  - IDLE: if pending!=0 and mute=0 and player_busy=0 → ISSUE.
  - ISSUE, one cycle:
    - sound_code <= picked code; play_sound=1 for exactly this cycle.
    - Clear the picked bit; active=1; start timer=0 → WAIT_START.
    - Sound latches the code on this pulse and raises start 1 cycle later.
  - WAIT_START:
    - player_busy=1 → WAIT_DONE.
    - Else timer increments; at timer==START_TIMEOUT-1 → timeout_err pulse, timeout_cnt+1 (saturating) → GAP.
  - WAIT_DONE: player_busy=0 → GAP, gap timer=0.
  - GAP: count GAP_CYCLES cycles → IDLE, active=0. If GAP_CYCLES=0, go to IDLE on the next cycle.
- IDLE with player_busy=1 (player started externally): the scheduler waits; no issue.
- Latency: req pulse in cycle N with the scheduler idle → play_sound in cycle N+2 (pending registered in N+1, ISSUE in N+2).
- Back-to-back: successive play_sound pulses are at least (player duration + GAP_CYCLES + 3) cycles apart.
- Output timing: play_sound and timeout_err are registered, single-cycle, and never asserted together. sound_code changes only in ISSUE.
- Pending bits are never lost except through mute.

Decomposition:
- Package sound_pkg:
  - code constants SND_SELECT=1 .. SND_GAMEOVER=7;
  - the priority order table;
  - FSM state enum (IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP).
- Sub-module sound_prio_pick: combinational 7-bit mask → 3-bit code plus one-hot clear mask, following the package order. The FSM, timers and counters stay in the top module.

Test Plan:
- Single request: req=7'b0000100 at cycle 10, player_busy rises 1 cycle after play_sound and lasts 50 cycles, GAP_CYCLES=4 → play_sound at cycle 12 with sound_code=3; active drops 5 cycles after busy falls; pending returns to 0.
- Simultaneous requests: req=7'b1010001 (codes 1, 5, 7) in one cycle → issue order 7, 5, 1, each after the previous busy+gap; coalesce_cnt=0.
- Coalesce: while code 3 is playing, pulse req bit2 three times → one further issue of code 3; coalesce_cnt=2.
- Timeout: player_busy tied low, START_TIMEOUT=16, one request → timeout_err 16 cycles after play_sound; timeout_cnt=1; state returns to IDLE after the gap; the pending bit is not re-issued.
- Mute and reset: pending=7'b0110000 and mute=1 → pending=0 and no play_sound. Assert rstn=0 mid-WAIT_DONE → all outputs 0 immediately. After release with busy low → IDLE.
- Set/clear race: req bit4 pulses in the same cycle code 5 is issued → bit4 remains pending; code 5 is reissued after the gap.
